// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default widths and depth helper for the register file
package regfile_pkg;
   typedef enum logic {RF_INIT, RF_RUN} rf_state_e;
   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational read mux with zero-register and write bypass
module regfile_read_port import regfile_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic [DATA_W*depth_of(ADDR_W)-1:0] regs_flat,
   input  logic                               ready,
   input  logic                               write_enable,
   input  logic [ADDR_W-1:0]                  write_addr,
   input  logic [DATA_W-1:0]                  write_data,
   input  logic [ADDR_W-1:0]                  read_addr,
   output logic [DATA_W-1:0]                  read_data
);
   logic zero_hit, byp_hit;
   always_comb begin
      zero_hit  = (ZERO_REG != 0) && (read_addr == '0);
      byp_hit   = (BYPASS != 0) && write_enable && (write_addr == read_addr);
      read_data = !ready   ? '0 :
                  zero_hit ? '0 :
                  byp_hit  ? write_data :
                  regs_flat[read_addr*DATA_W +: DATA_W];
   end
endmodule

// File: rtl/param_register_file.sv
// param_register_file: 2R1W register file with post-reset clearing sweep and ready flag
module param_register_file import regfile_pkg::*; #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              ready,
   output logic              wr_drop
);
   localparam int DEPTH = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   rf_state_e                 state_q, state_d;
   logic [ADDR_W-1:0]         sweep_ptr_q, sweep_ptr_d;
   logic                      ready_q, ready_d;
   logic                      wr_drop_q, wr_drop_d;
   logic [DEPTH*DATA_W-1:0]   regs_q, regs_d;
   logic                      zero_wr;
   always_comb begin
      state_d     = (state_q == RF_INIT && sweep_ptr_q == LAST) ? RF_RUN : state_q;
      sweep_ptr_d = (state_q == RF_INIT) ? sweep_ptr_q + 1'b1 : sweep_ptr_q;
      ready_d     = (state_d == RF_RUN);
      wr_drop_d   = write_enable && !ready_q;
   end
   // Array has no reset of its own; the sweep clears it one entry per cycle.
   always_comb begin
      zero_wr = (ZERO_REG != 0) && (write_addr == '0);
      regs_d  = regs_q;
      if (rst_n && state_q == RF_INIT)
         regs_d[sweep_ptr_q*DATA_W +: DATA_W] = '0;
      else if (rst_n && ready_q && write_enable && !zero_wr)
         regs_d[write_addr*DATA_W +: DATA_W] = write_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RF_INIT;
         sweep_ptr_q <= '0;
         ready_q     <= 1'b0;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_ptr_q <= sweep_ptr_d;
         ready_q     <= ready_d;
         wr_drop_q   <= wr_drop_d;
      end
      regs_q <= regs_d;
   end
   assign ready   = ready_q;
   assign wr_drop = wr_drop_q;
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp1 (
      .regs_flat(regs_q), .ready(ready_q), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr(read_addr1), .read_data(read_data1)
   );
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rp2 (
      .regs_flat(regs_q), .ready(ready_q), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr(read_addr2), .read_data(read_data2)
   );
endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: scoreboard bench for default and zero-reg/no-bypass builds
module tb_param_register_file;
   logic       clk = 0, rst_n = 0, write_enable = 0;
   logic [1:0] write_addr = 0, read_addr1 = 0, read_addr2 = 0;
   logic [7:0] write_data = 0;
   logic [7:0] rd1_a, rd2_a, rd1_z, rd2_z;
   logic       rdy_a, rdy_z, drop_a, drop_z;
   always #5 clk = ~clk;
   param_register_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(rd1_a), .read_data2(rd2_a), .ready(rdy_a), .wr_drop(drop_a)
   );
   param_register_file #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
      .read_data1(rd1_z), .read_data2(rd2_z), .ready(rdy_z), .wr_drop(drop_z)
   );
   typedef struct packed {
      logic [7:0] r1a, r2a, r1z, r2z;
      logic       rdy, drop;
   } exp_t;
   exp_t       sb[$];
   exp_t       e_mon;
   logic [7:0] mem_a[4], mem_z[4];
   int         since_rst = 0;
   logic       m_drop = 0;
   int         vectors = 0, miscompares = 0;
   // Reference: the array is usable once four clean edges have passed since reset.
   function automatic logic [7:0] rd(input bit zr, input bit byp, input logic [1:0] a, input logic [7:0] v);
      if (since_rst < 4) return 8'h00;
      if (zr && a == 2'd0) return 8'h00;
      if (byp && write_enable && write_addr == a) return write_data;
      return v;
   endfunction
   task automatic model_edge();
      if (!rst_n) begin
         since_rst = 0;
         m_drop = 0;
      end else if (since_rst < 4) begin
         mem_a[since_rst] = 8'h00;
         mem_z[since_rst] = 8'h00;
         m_drop = write_enable;
         since_rst++;
      end else begin
         m_drop = 0;
         if (write_enable) begin
            mem_a[write_addr] = write_data;
            if (write_addr != 2'd0) mem_z[write_addr] = write_data;
         end
      end
   endtask
   task automatic cyc(input bit r, input bit we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic [1:0] a1, input logic [1:0] a2);
      exp_t e;
      rst_n = r; write_enable = we; write_addr = wa; write_data = wd;
      read_addr1 = a1; read_addr2 = a2;
      e.r1a = rd(0, 1, a1, mem_a[a1]);
      e.r2a = rd(0, 1, a2, mem_a[a2]);
      e.r1z = rd(1, 0, a1, mem_z[a1]);
      e.r2z = rd(1, 0, a2, mem_z[a2]);
      e.rdy = since_rst >= 4;
      e.drop = m_drop;
      sb.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask
   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %02h expected %02h", n, $time, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e_mon = sb.pop_front();
         chk("rd1_a", rd1_a, e_mon.r1a);
         chk("rd2_a", rd2_a, e_mon.r2a);
         chk("rd1_z", rd1_z, e_mon.r1z);
         chk("rd2_z", rd2_z, e_mon.r2z);
         chk("ready_a", {7'b0, rdy_a}, {7'b0, e_mon.rdy});
         chk("ready_z", {7'b0, rdy_z}, {7'b0, e_mon.rdy});
         chk("wr_drop_a", {7'b0, drop_a}, {7'b0, e_mon.drop});
         chk("wr_drop_z", {7'b0, drop_z}, {7'b0, e_mon.drop});
      end
   end
   initial begin
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = 8'h00;
         mem_z[i] = 8'h00;
      end
      @(posedge clk);
      model_edge();
      #1;
      repeat (3) cyc(0, 1, 2'd2, 8'h33, 2'd0, 2'd1);
      cyc(1, 0, 2'd0, 8'h00, 2'd2, 2'd3);
      cyc(1, 1, 2'd2, 8'hAA, 2'd2, 2'd0);
      cyc(1, 0, 2'd0, 8'h00, 2'd2, 2'd1);
      cyc(1, 0, 2'd0, 8'h00, 2'd2, 2'd3);
      for (int a = 0; a < 4; a++) cyc(1, 0, 2'd0, 8'h00, 2'(a), 2'(3 - a));
      cyc(1, 1, 2'd1, 8'h5C, 2'd1, 2'd3);
      cyc(1, 0, 2'd0, 8'h00, 2'd1, 2'd3);
      cyc(1, 1, 2'd3, 8'h11, 2'd0, 2'd3);
      cyc(1, 1, 2'd3, 8'h77, 2'd1, 2'd3);
      cyc(1, 0, 2'd0, 8'h00, 2'd3, 2'd3);
      cyc(1, 1, 2'd0, 8'hFF, 2'd0, 2'd0);
      cyc(1, 0, 2'd0, 8'h00, 2'd0, 2'd1);
      for (int a = 0; a < 4; a++) cyc(1, 1, 2'(a), 8'(a + 1), 2'(a), 2'(a));
      cyc(0, 1, 2'd1, 8'h99, 2'd1, 2'd2);
      for (int a = 0; a < 6; a++) cyc(1, 0, 2'd0, 8'h00, 2'(a), 2'(a + 1));
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
